// File: rtl/sm_imem_loader_pkg.sv
// Shared types and helpers for the schoolRISCV instruction-memory loader.
package sm_imem_loader_pkg;

    // Loader frame states
    typedef enum logic [2:0] {
        LdrIdle  = 3'd0,
        LdrLenLo = 3'd1,
        LdrLenHi = 3'd2,
        LdrData  = 3'd3,
        LdrCsum  = 3'd4,
        LdrDone  = 3'd5,
        LdrErr   = 3'd6
    } ldr_state_e;

    // Default frame start byte
    localparam logic [7:0] LdrHeaderDefault = 8'hA5;

    // Running checksum is a plain XOR over the data bytes only
    function automatic logic [7:0] ldr_csum_next(input logic [7:0] csum, input logic [7:0] data);
        return csum ^ data;
    endfunction

endpackage

// File: rtl/sm_loader_word_asm.sv
// Little-endian byte-lane assembler: collects four accepted bytes into a word and
// raises a one-cycle write strobe the cycle after lane 3 arrives.
module sm_loader_word_asm (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_byte,
    input  logic        i_accept,
    input  logic        i_clear,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic [1:0]  o_byte_idx
);

    logic [31:0] r_word;
    logic [1:0]  r_byte_idx;
    logic        r_word_valid;

    // Lane placement, lane counter and write strobe
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_word       <= '0;
            r_byte_idx   <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_byte_idx <= '0;
            end else if (i_accept) begin
                unique case (r_byte_idx)
                    2'd0: r_word[7:0]   <= i_byte;
                    2'd1: r_word[15:8]  <= i_byte;
                    2'd2: r_word[23:16] <= i_byte;
                    2'd3: r_word[31:24] <= i_byte;
                    default: ;
                endcase
                // Counter wraps 3 -> 0 naturally
                r_byte_idx   <= r_byte_idx + 2'd1;
                r_word_valid <= (r_byte_idx == 2'd3);
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_byte_idx   = r_byte_idx;

endmodule

// File: rtl/sm_imem_loader.sv
// Framed byte-stream program loader: writes words into instruction memory and holds
// the CPU in reset until a checksum-verified image has been received.
module sm_imem_loader
    import sm_imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned TIMEOUT    = 1000,
    parameter logic [7:0]  HEADER     = LdrHeaderDefault
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_in_valid,
    input  logic [7:0]            i_in_data,
    output logic                  o_in_ready,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [31:0]           o_imem_wdata,
    output logic                  o_cpu_hold,
    output logic                  o_load_done,
    output logic                  o_load_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    ldr_state_e            r_state;
    logic [15:0]           r_len;
    logic [7:0]            r_csum;
    logic [ADDR_WIDTH-1:0] r_word_idx;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [CntW-1:0]       r_idle_cnt;
    logic                  r_in_ready;
    logic                  r_cpu_hold;
    logic                  r_load_done;
    logic                  r_load_err;

    logic                  w_accept;
    logic                  w_between;
    logic                  w_start;
    logic                  w_asm_accept;
    logic [31:0]           w_len_full;
    logic [31:0]           w_depth;
    logic                  w_last_word;
    logic [31:0]           w_word;
    logic                  w_word_valid;
    logic [1:0]            w_byte_idx;

    assign w_accept     = i_in_valid && r_in_ready;
    assign w_between    = (r_state == LdrIdle) || (r_state == LdrDone) || (r_state == LdrErr);
    assign w_start      = w_accept && w_between && (i_in_data == HEADER);
    assign w_asm_accept = w_accept && (r_state == LdrData);
    assign w_len_full   = {16'd0, i_in_data, r_len[7:0]};
    assign w_depth      = 32'd1 << ADDR_WIDTH;
    // Compare in 32 bits so a full-capacity frame never wraps the word index
    assign w_last_word  = ({{(32 - ADDR_WIDTH){1'b0}}, r_word_idx} + 32'd1) == {16'd0, r_len};

    sm_loader_word_asm u_word_asm (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_byte       (i_in_data),
        .i_accept     (w_asm_accept),
        .i_clear      (w_start),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_byte_idx   (w_byte_idx)
    );

    // Frame FSM with length check, checksum, timeout and registered status outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= LdrIdle;
            r_len       <= '0;
            r_csum      <= '0;
            r_word_idx  <= '0;
            r_imem_addr <= '0;
            r_idle_cnt  <= '0;
            r_in_ready  <= 1'b0;
            r_cpu_hold  <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_in_ready <= 1'b1;
            if (w_between) begin
                r_idle_cnt <= '0;
                if (w_start) begin
                    r_state     <= LdrLenLo;
                    r_cpu_hold  <= 1'b1;
                    r_load_done <= 1'b0;
                    r_load_err  <= 1'b0;
                    r_csum      <= '0;
                    r_word_idx  <= '0;
                end
            end else if (!w_accept) begin
                // An accepted byte always wins over the timeout
                if (r_idle_cnt == CntLast) begin
                    r_state    <= LdrErr;
                    r_load_err <= 1'b1;
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end else begin
                r_idle_cnt <= '0;
                case (r_state)
                    LdrLenLo: begin
                        r_len[7:0] <= i_in_data;
                        r_state    <= LdrLenHi;
                    end
                    LdrLenHi: begin
                        r_len[15:8] <= i_in_data;
                        if (w_len_full > w_depth) begin
                            r_state    <= LdrErr;
                            r_load_err <= 1'b1;
                        end else if (w_len_full == 32'd0) begin
                            r_state <= LdrCsum;
                        end else begin
                            r_state <= LdrData;
                        end
                    end
                    LdrData: begin
                        r_csum <= ldr_csum_next(r_csum, i_in_data);
                        if (w_byte_idx == 2'd3) begin
                            r_imem_addr <= r_word_idx;
                            if (w_last_word) begin
                                r_state <= LdrCsum;
                            end else begin
                                r_word_idx <= r_word_idx + 1'b1;
                            end
                        end
                    end
                    LdrCsum: begin
                        if (i_in_data == r_csum) begin
                            r_state     <= LdrDone;
                            r_load_done <= 1'b1;
                            r_cpu_hold  <= 1'b0;
                        end else begin
                            r_state    <= LdrErr;
                            r_load_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_imem_we    = w_word_valid;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = w_word;
    assign o_cpu_hold   = r_cpu_hold;
    assign o_load_done  = r_load_done;
    assign o_load_err   = r_load_err;

endmodule

// File: tb/tb_sm_imem_loader.sv
// Self-checking bench for sm_imem_loader: frame-level reference model plus directed
// and randomized frames.
module tb_sm_imem_loader;

    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;
    localparam int TO    = 50;
    localparam logic [7:0] HDR = 8'hA5;

    logic          clk;
    logic          rst;
    logic          tb_valid;
    logic [7:0]    tb_data;
    logic          o_in_ready;
    logic          o_imem_we;
    logic [AW-1:0] o_imem_addr;
    logic [31:0]   o_imem_wdata;
    logic          o_cpu_hold;
    logic          o_load_done;
    logic          o_load_err;

    sm_imem_loader #(
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO),
        .HEADER     (HDR)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_in_valid   (tb_valid),
        .i_in_data    (tb_data),
        .o_in_ready   (o_in_ready),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_cpu_hold   (o_cpu_hold),
        .o_load_done  (o_load_done),
        .o_load_err   (o_load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame position based) ----------------
    bit          m_ready, m_active, m_hold, m_done, m_err, m_we;
    int          m_pos, m_len, m_idle, m_addr;
    logic [7:0]  m_csum;
    logic [31:0] m_word, m_wdata;

    task automatic model_reset();
        m_ready = 0; m_active = 0; m_hold = 0; m_done = 0; m_err = 0; m_we = 0;
        m_pos = 0; m_len = 0; m_idle = 0; m_addr = 0; m_csum = 0; m_word = 0; m_wdata = 0;
    endtask

    task automatic model_fail();
        m_active = 0;
        m_err    = 1;
    endtask

    task automatic model_step();
        bit acc;
        int k;
        acc  = tb_valid && m_ready;
        m_we = 0;
        if (!m_active) begin
            if (acc && tb_data == HDR) begin
                m_active = 1; m_pos = 0; m_hold = 1; m_done = 0; m_err = 0;
                m_csum = 0; m_idle = 0;
            end
        end else if (acc) begin
            m_idle = 0;
            if (m_pos == 0) begin
                m_len = int'(tb_data);
            end else if (m_pos == 1) begin
                m_len = m_len + 256 * int'(tb_data);
                if (m_len > DEPTH) model_fail();
            end else begin
                k = m_pos - 2;
                if (k < 4 * m_len) begin
                    m_csum = m_csum ^ tb_data;
                    m_word[8*(k%4) +: 8] = tb_data;
                    if (k % 4 == 3) begin
                        m_we = 1; m_addr = k / 4; m_wdata = m_word;
                    end
                end else if (tb_data == m_csum) begin
                    m_active = 0; m_done = 1; m_hold = 0;
                end else begin
                    model_fail();
                end
            end
            m_pos++;
        end else begin
            m_idle++;
            if (m_idle == TO) model_fail();
        end
        m_ready = 1;
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else model_step();
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(o_in_ready), 32'(m_ready));
            chk("imem_we", 32'(o_imem_we), 32'(m_we));
            chk("cpu_hold", 32'(o_cpu_hold), 32'(m_hold));
            chk("load_done", 32'(o_load_done), 32'(m_done));
            chk("load_err", 32'(o_load_err), 32'(m_err));
            if (m_we) begin
                chk("imem_addr", 32'(o_imem_addr), 32'(m_addr));
                chk("imem_wdata", o_imem_wdata, m_wdata);
            end
        end
    end

    // Capture of DUT writes, used only for literal end-of-test expectations
    logic [31:0] dut_mem [DEPTH];
    int          dut_last_addr = -1;
    int          dut_we_cnt    = 0;
    always @(negedge clk) begin
        if (!rst && o_imem_we) begin
            dut_mem[o_imem_addr] = o_imem_wdata;
            dut_last_addr        = int'(o_imem_addr);
            dut_we_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        if (gap > 0) idle(gap);
        tb_valid = 1'b1;
        tb_data  = b;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        tb_data  = $urandom_range(0, 255);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ready", 32'(o_in_ready), 32'd0);
        chk("rst_we", 32'(o_imem_we), 32'd0);
        chk("rst_addr", 32'(o_imem_addr), 32'd0);
        chk("rst_hold", 32'(o_cpu_hold), 32'd0);
        chk("rst_done", 32'(o_load_done), 32'd0);
        chk("rst_err", 32'(o_load_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
    endtask

    logic [7:0] f1 [12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
                            8'h6F, 8'h00, 8'h00, 8'h00, 8'h29};

    task automatic send_f1(input logic [7:0] csum);
        for (int i = 0; i < 11; i++) send_byte(f1[i], 0);
        send_byte(csum, 0);
    endtask

    // Random frame: noise, header, length, data with random gaps, maybe bad checksum
    task automatic rand_frame();
        int         len, gap, nbytes;
        logic [7:0] cs, b;
        int         sel;
        for (int i = 0; i < $urandom_range(0, 2); i++) send_byte(8'($urandom_range(0, 255)), 0);
        sel = $urandom_range(0, 9);
        if (sel < 7) len = $urandom_range(0, 6);
        else if (sel < 9) len = $urandom_range(60, 64);
        else len = $urandom_range(65, 300);
        send_byte(HDR, $urandom_range(0, 2));
        send_byte(8'(len), $urandom_range(0, 2));
        send_byte(8'(len >> 8), $urandom_range(0, 2));
        nbytes = (len > DEPTH) ? 3 : 4 * len;
        cs = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            b   = 8'($urandom_range(0, 255));
            cs  = cs ^ b;
            gap = ($urandom_range(0, 99) < 2) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(0, 2);
            if ($urandom_range(0, 99) < 1) begin
                do_reset();
                return;
            end
            send_byte(b, gap);
        end
        if ($urandom_range(0, 4) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
        send_byte(cs, $urandom_range(0, 2));
        idle($urandom_range(0, 3));
    endtask

    int we_before;

    initial begin
        tb_valid = 1'b0;
        tb_data  = 8'h00;
        rst      = 1'b0;
        do_reset();
        idle(1);

        // Two-word load
        send_f1(8'h29);
        chk("t1_mem0", dut_mem[0], 32'h00500513);
        chk("t1_mem1", dut_mem[1], 32'h0000006F);
        chk("t1_done", 32'(o_load_done), 32'd1);
        chk("t1_hold", 32'(o_cpu_hold), 32'd0);
        idle(2);

        // Bad checksum
        dut_mem[0] = 32'h0; dut_mem[1] = 32'h0;
        send_f1(8'h28);
        chk("t2_err", 32'(o_load_err), 32'd1);
        chk("t2_hold", 32'(o_cpu_hold), 32'd1);
        chk("t2_done", 32'(o_load_done), 32'd0);
        chk("t2_mem1", dut_mem[1], 32'h0000006F);
        idle(2);

        // Over-length frame, then full-capacity frame
        we_before = dut_we_cnt;
        send_byte(HDR, 0); send_byte(8'h41, 0); send_byte(8'h00, 0);
        chk("t3_err", 32'(o_load_err), 32'd1);
        idle(3);
        chk("t3_nowrite", 32'(dut_we_cnt), 32'(we_before));
        send_byte(HDR, 0); send_byte(8'h40, 0); send_byte(8'h00, 0);
        for (int i = 0; i < 256; i++) send_byte(8'(i), 0);
        send_byte(8'h00, 0);  // XOR of 0..255 is 0
        chk("t3_last_addr", 32'(dut_last_addr), 32'd63);
        chk("t3_mem63", dut_mem[63], 32'hFFFEFDFC);
        chk("t3_done", 32'(o_load_done), 32'd1);
        chk("t3_writes", 32'(dut_we_cnt - we_before), 32'd64);
        idle(2);

        // Noise between frames, then empty frame
        we_before = dut_we_cnt;
        send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h13, 0);
        chk("t4_hold", 32'(o_cpu_hold), 32'd0);
        send_byte(HDR, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        chk("t4_done", 32'(o_load_done), 32'd1);
        idle(2);
        chk("t4_nowrite", 32'(dut_we_cnt), 32'(we_before));

        // Timeout mid-word
        send_byte(HDR, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h05, 0);
        idle(TO - 1);
        chk("t5_err_early", 32'(o_load_err), 32'd0);
        idle(1);
        chk("t5_err", 32'(o_load_err), 32'd1);
        chk("t5_nowrite", 32'(dut_we_cnt), 32'(we_before));
        send_byte(HDR, 0);
        chk("t5_restart_err", 32'(o_load_err), 32'd0);
        chk("t5_restart_hold", 32'(o_cpu_hold), 32'd1);
        idle(TO + 2);

        // Reset mid-frame, then a clean reload from address 0
        send_byte(HDR, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        do_reset();
        dut_mem[0] = 32'h0;
        send_f1(8'h29);
        chk("t6_mem0", dut_mem[0], 32'h00500513);
        chk("t6_done", 32'(o_load_done), 32'd1);
        idle(2);

        // Randomized frames
        for (int f = 0; f < 60; f++) rand_frame();
        idle(TO + 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
